// File: rtl/iter_divider.sv
// Purpose : iterative radix-2 restoring divider (RV64M DIV/DIVU/REM/REMU); optional DIV_EARLY_OUT_EN.
// Latency : accept in T -> div_o_valid from T+WIDTH+2; B==0 / signed overflow from T+1; early-out from T+2.
// Backpr. : result held stable in DONE until div_o_ready; new requests only sampled in IDLE.
module iter_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_flush,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_o_valid,
  input  logic             div_o_ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend shift register: dividend bits leave at the MSB while quotient
  // bits enter at the LSB, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero, sgn_ovf, early_out;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  // Operand magnitudes and special-case detection for the accept cycle
  always_comb begin
    a_neg   = div_signed & dividend[WIDTH-1];
    b_neg   = div_signed & divisor[WIDTH-1];
    abs_a   = a_neg ? ('0 - dividend) : dividend;
    abs_b   = b_neg ? ('0 - divisor)  : divisor;
    b_zero  = (divisor == '0);
    sgn_ovf = div_signed & (dividend == MIN_NEG) & (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early_out = (abs_a < abs_b);
`else
    early_out = 1'b0;
`endif
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {part_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    trial   = shifted - {1'b0, dvs_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = valid_q;

    if (div_flush) begin
      // Flush wins over everything, including a same-cycle request.
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_valid) begin
            cnt_d   = '0;
            dvd_d   = abs_a;
            dvs_d   = abs_b;
            part_d  = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            if (b_zero) begin
              quotient_d  = '1;
              remainder_d = dividend;
              valid_d     = 1'b1;
              state_d     = DONE;
            end else if (sgn_ovf) begin
              quotient_d  = dividend;
              remainder_d = '0;
              valid_d     = 1'b1;
              state_d     = DONE;
            end else if (early_out) begin
              // |A| < |B|: quotient is zero, remainder is |A| before sign fix.
              dvd_d   = '0;
              part_d  = abs_a;
              state_d = FIX;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          dvd_d  = {dvd_q[WIDTH-2:0], fits};
          part_d = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quotient_d  = q_neg_q ? ('0 - dvd_q)  : dvd_q;
          remainder_d = r_neg_q ? ('0 - part_q) : part_q;
          valid_d     = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (div_o_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_o_valid = valid_q;

endmodule

// File: tb/tb_iter_divider.sv
// Purpose : self-checking bench for iter_divider (vector table, corner sequences, random vs model).
// Latency : expectations derived from the operation class (special, early-out, full iteration).
// Backpr. : exercises ready held low, back-to-back requests, flush and async reset.
module tb_iter_divider;

  localparam int W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam int FULL = W + 2;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int EO = EARLY ? 2 : FULL;

  logic        clk, rst, div_flush, div_valid, div_signed, div_o_ready;
  logic [63:0] dividend, divisor, quotient, remainder;
  logic        div_o_valid;

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_flush   (div_flush),
    .div_valid   (div_valid),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_o_valid (div_o_valid),
    .div_o_ready (div_o_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] q, output logic [63:0] r, output int lat);
    logic signed [63:0] sa, sb;
    logic [63:0] ma, mb;
    sa = a;
    sb = b;
    ma = (s && a[63]) ? (64'd0 - a) : a;
    mb = (s && b[63]) ? (64'd0 - b) : b;
    if (b == 64'd0) begin
      q = ONES; r = a; lat = 1;
    end else if (s && a == MIN && b == ONES) begin
      q = MIN; r = 64'd0; lat = 1;
    end else begin
      if (s) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
      lat = (EARLY && ma < mb) ? 2 : FULL;
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    @(negedge clk);
    div_valid = 1'b1; dividend = a; divisor = b; div_signed = s;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  // Cycles from the accept cycle to the first cycle with div_o_valid high; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!div_o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!div_o_valid) lat = -1;
  endtask

  task automatic handshake(input string tag);
    div_o_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drop"}, 64'(div_o_valid), 64'd0);
    div_o_ready = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input int hold,
                        output logic [63:0] q, output logic [63:0] r, output int lat);
    start_op(a, b, s);
    wait_result(lat);
    q = quotient;
    r = remainder;
    // A request during DONE must be ignored and must not disturb the result.
    div_valid = 1'b1; dividend = 64'd1; divisor = 64'd1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_q", quotient, q);
      chk("hold_r", remainder, r);
      chk("hold_vld", 64'(div_o_valid), 64'd1);
    end
    div_valid = 1'b0;
    handshake("op");
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q, r, eq, er, a, b;
    logic        s;
    int          lat, elat, mode;

    vecs[0]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, FULL};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES, FULL};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, FULL};
    vecs[3]  = '{64'd5, 64'd0, 1'b0, ONES, 64'd5, 1};
    vecs[4]  = '{64'd5, 64'd0, 1'b1, ONES, 64'd5, 1};
    vecs[5]  = '{MIN, ONES, 1'b1, MIN, 64'd0, 1};
    vecs[6]  = '{MIN, ONES, 1'b0, 64'd0, MIN, EO};
    vecs[7]  = '{64'd3, 64'd10, 1'b0, 64'd0, 64'd3, EO};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, EO};
    vecs[9]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, FULL};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'd3, ONES, FULL};
    vecs[11] = '{ONES, 64'd1, 1'b0, ONES, 64'd0, FULL};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFFB, 1};
    vecs[13] = '{64'd0, 64'd5, 1'b1, 64'd0, 64'd0, EO};
    vecs[14] = '{64'h10, 64'h10, 1'b0, 64'd1, 64'd0, FULL};

    rst = 1'b1; div_flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    div_o_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    chk("reset_vld", 64'(div_o_valid), 64'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, (i % 3 == 0) ? 3 : 0, q, r, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Flush in CALC cycle 10 while a new request is already waiting
    start_op(64'd100, 64'd7, 1'b0);
    repeat (9) @(negedge clk);
    div_flush = 1'b1; div_valid = 1'b1; dividend = 64'd1000; divisor = 64'd33; div_signed = 1'b0;
    @(negedge clk);
    chk("flush_vld", 64'(div_o_valid), 64'd0);
    div_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    wait_result(lat);
    chk("flush_lat", 64'(lat), 64'(FULL));
    chk("flush_q", quotient, 64'd30);
    chk("flush_r", remainder, 64'd10);
    handshake("flush");

    // Flush while holding a result in DONE
    start_op(64'd9, 64'd2, 1'b0);
    wait_result(lat);
    chk("flushdone_pre", 64'(div_o_valid), 64'd1);
    div_flush = 1'b1;
    @(negedge clk);
    chk("flushdone_vld", 64'(div_o_valid), 64'd0);
    div_flush = 1'b0;

    // Back-to-back: request held through the handshake
    start_op(64'd100, 64'd7, 1'b0);
    wait_result(lat);
    chk("b2b_first_q", quotient, 64'd14);
    div_o_ready = 1'b1; div_valid = 1'b1; dividend = 64'd5; divisor = 64'd0;
    @(negedge clk);
    chk("b2b_gap", 64'(div_o_valid), 64'd0);
    @(negedge clk);
    chk("b2b_vld", 64'(div_o_valid), 64'd1);
    chk("b2b_q", quotient, ONES);
    chk("b2b_r", remainder, 64'd5);
    div_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drop", 64'(div_o_valid), 64'd0);
    div_o_ready = 1'b0;

    // Async reset while a result is held, then while iterating
    start_op(64'd100, 64'd7, 1'b0);
    wait_result(lat);
    rst = 1'b1;
    #1;
    chk("arst_q", quotient, 64'd0);
    chk("arst_r", remainder, 64'd0);
    chk("arst_vld", 64'(div_o_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(64'd100, 64'd7, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_calc_vld", 64'(div_o_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd45, 64'd6, 1'b0, 1, q, r, lat);
    chk("post_rst_q", q, 64'd7);
    chk("post_rst_r", r, 64'd3);
    chk("post_rst_lat", 64'(lat), 64'(FULL));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (mode)
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 20));
        3: a = 64'($urandom_range(0, 1000));
        4: begin a = MIN; b = ONES; s = 1'b1; end
        5: b = 64'd0 - 64'($urandom_range(1, 50));
        default: ;
      endcase
      model(a, b, s, eq, er, elat);
      run_op(a, b, s, $urandom_range(0, 2), q, r, lat);
      chk($sformatf("rnd%0d_q", i), q, eq);
      chk($sformatf("rnd%0d_r", i), r, er);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
